// File: rtl/operand_entry_if.sv
// Keypad-side and consumer-side signals of the operand entry stage.
// The slave modport is the entry block; the master modport is the environment around it.
interface operand_entry_if #(
  parameter int WIDTH = 16
);
  logic             key_valid;
  logic [4:0]       key_code;
  logic             key_ready;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] disp_out;
  logic             entering_y;
  logic [2:0]       digit_cnt;
  logic             ovf;

  modport slave (
    input  key_valid, key_code, op_ready,
    output key_ready, x_out, y_out, op_valid, disp_out, entering_y, digit_cnt, ovf
  );

  modport master (
    output key_valid, key_code, op_ready,
    input  key_ready, x_out, y_out, op_valid, disp_out, entering_y, digit_cnt, ovf
  );
endinterface

// File: rtl/operand_entry.sv
// Builds two hex operands from keypad digit codes and offers them as a pair
// through a valid/ready handshake; all outputs are registers or state decodes.
module operand_entry #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  operand_entry_if.slave  bus
);
  localparam int DIGITS = WIDTH / 4;
  localparam logic [2:0] CNT_MAX   = 3'(DIGITS);
  localparam logic [4:0] KEY_ENTER = 5'h10;
  localparam logic [4:0] KEY_CLEAR = 5'h11;

  typedef enum logic [1:0] {
    S_X     = 2'd0,
    S_Y     = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [2:0]       cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;

  logic             key_ready;
  logic             key_fire;
  logic             is_digit;
  logic [WIDTH-1:0] edit_op;
  logic [WIDTH-1:0] edit_shift;

  assign key_ready = (state_reg != S_ISSUE);
  assign key_fire  = bus.key_valid && key_ready;
  assign is_digit  = !bus.key_code[4];
  assign edit_op   = (state_reg == S_X) ? x_reg : y_reg;

  // Nibble-lane shift: the new digit enters the least significant nibble.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nibble
      if (gi == 0) begin : g_low
        assign edit_shift[3:0] = bus.key_code[3:0];
      end else begin : g_up
        assign edit_shift[gi*4 +: 4] = edit_op[(gi-1)*4 +: 4];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_X;
      x_reg     <= '0;
      y_reg     <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      S_X, S_Y: begin
        if (key_fire) begin
          if (is_digit) begin
            // A full operand ignores further digits and only flags overflow.
            if (cnt_reg == CNT_MAX) begin
              ovf_next = 1'b1;
            end else begin
              if (state_reg == S_X) begin
                x_next = edit_shift;
              end else begin
                y_next = edit_shift;
              end
              cnt_next = cnt_reg + 3'd1;
            end
          end else if (bus.key_code == KEY_ENTER) begin
            if (state_reg == S_X) begin
              state_next = S_Y;
              cnt_next   = '0;
              y_next     = '0;
            end else begin
              state_next = S_ISSUE;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            state_next = S_X;
            x_next     = '0;
            y_next     = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        if (bus.op_ready) begin
          state_next = S_X;
          x_next     = '0;
          y_next     = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      end
      default: begin
        state_next = S_X;
      end
    endcase
  end

  assign bus.key_ready  = key_ready;
  assign bus.op_valid   = (state_reg == S_ISSUE);
  assign bus.entering_y = (state_reg == S_Y);
  assign bus.x_out      = x_reg;
  assign bus.y_out      = y_reg;
  assign bus.disp_out   = edit_op;
  assign bus.digit_cnt  = cnt_reg;
  assign bus.ovf        = ovf_reg;
endmodule

// File: tb/tb_operand_entry.sv
// Directed and random keypad traffic against a digit-accumulator model of operand entry.
module tb_operand_entry;
  localparam int WIDTH  = 16;
  localparam int DIGITS = WIDTH / 4;
  localparam int MASK   = (1 << WIDTH) - 1;
  localparam logic [4:0] K_ENTER = 5'h10;
  localparam logic [4:0] K_CLEAR = 5'h11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_entry_if #(.WIDTH(WIDTH)) bus ();

  operand_entry #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: the two operands as plain numbers, how many digits the current one holds,
  // whether Y is being typed, and whether a finished pair is waiting for the consumer.
  int m_x, m_y, m_cnt;
  bit m_ovf, m_in_y, m_pending;
  int pairs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_x = 0; m_y = 0; m_cnt = 0;
    m_ovf = 0; m_in_y = 0; m_pending = 0;
  endfunction

  task automatic check_all();
    chk("key_ready", 32'(bus.key_ready), 32'(!m_pending));
    chk("op_valid", 32'(bus.op_valid), 32'(m_pending));
    chk("x_out", 32'(bus.x_out), 32'(m_x));
    chk("y_out", 32'(bus.y_out), 32'(m_y));
    chk("disp_out", 32'(bus.disp_out), 32'(m_in_y ? m_y : m_x));
    chk("entering_y", 32'(bus.entering_y), 32'(m_in_y && !m_pending));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    if (!m_pending) chk("digit_cnt", 32'(bus.digit_cnt), 32'(m_cnt));
  endtask

  // One clock: drive inputs, advance the model with what the edge sees, then compare.
  task automatic cycle(input bit kv, input logic [4:0] kc, input bit ordy);
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.op_ready  = ordy;
    @(posedge clk);
    if (m_pending) begin
      if (ordy) begin
        pairs++;
        $display("pair %0d x=0x%04h y=0x%04h", pairs, m_x, m_y);
        model_clear();
      end
    end else if (kv) begin
      if (kc < 5'h10) begin
        if (m_cnt < DIGITS) begin
          if (m_in_y) m_y = (m_y * 16 + int'(kc)) & MASK;
          else        m_x = (m_x * 16 + int'(kc)) & MASK;
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end else if (kc == K_ENTER) begin
        if (!m_in_y) begin
          m_in_y = 1; m_cnt = 0;
        end else begin
          m_pending = 1;
        end
      end else if (kc == K_CLEAR) begin
        model_clear();
      end
    end
    #1;
    check_all();
  endtask

  task automatic key(input logic [4:0] kc);
    cycle(1'b1, kc, 1'b1);
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 5'h00, ordy);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 5'h00;
    bus.op_ready  = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_key_ready", 32'(bus.key_ready), 32'd1);
    rst_n = 1'b1;

    // Plan 1: full pair with consumer always ready.
    key(5'hA); key(5'hB); key(5'hC); key(5'hD); key(K_ENTER);
    key(5'h0); key(5'hF); key(5'h0); key(5'hF); key(K_ENTER);
    chk("t1_valid", 32'(bus.op_valid), 32'd1);
    chk("t1_x", 32'(bus.x_out), 32'hABCD);
    chk("t1_y", 32'(bus.y_out), 32'h0F0F);
    idle(1'b1);
    chk("t1_cleared_valid", 32'(bus.op_valid), 32'd0);
    chk("t1_cleared_x", 32'(bus.x_out), 32'h0);

    // Plan 2: overflow and an empty Y.
    key(5'h1); key(5'h2); key(5'h3); key(5'h4); key(5'h5);
    chk("t2_x", 32'(bus.x_out), 32'h1234);
    chk("t2_cnt", 32'(bus.digit_cnt), 32'd4);
    chk("t2_ovf", 32'(bus.ovf), 32'd1);
    cycle(1'b1, K_ENTER, 1'b0); cycle(1'b1, K_ENTER, 1'b0);
    chk("t2_y", 32'(bus.y_out), 32'h0);
    idle(1'b1);
    chk("t2_ovf_after", 32'(bus.ovf), 32'd0);

    // Plan 3: back-pressure while a digit is held upstream.
    cycle(1'b1, 5'h1, 1'b0); cycle(1'b1, K_ENTER, 1'b0);
    cycle(1'b1, 5'h2, 1'b0); cycle(1'b1, K_ENTER, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 5'h7, 1'b0);
      chk("t3_hold_ready", 32'(bus.key_ready), 32'd0);
      chk("t3_hold_x", 32'(bus.x_out), 32'h1);
    end
    cycle(1'b1, 5'h7, 1'b1);
    cycle(1'b1, 5'h7, 1'b0);
    chk("t3_x7", 32'(bus.x_out), 32'h0007);
    key(K_CLEAR);

    // Plan 4: CLEAR from Y editing.
    key(5'h9); key(K_ENTER); key(5'h5); key(K_CLEAR); key(5'h3);
    chk("t4_x", 32'(bus.x_out), 32'h0003);
    chk("t4_y", 32'(bus.y_out), 32'h0);
    chk("t4_ey", 32'(bus.entering_y), 32'd0);
    key(K_CLEAR);

    // Plan 5: asynchronous reset with a pair pending.
    cycle(1'b1, 5'hB, 1'b0); cycle(1'b1, 5'hE, 1'b0); cycle(1'b1, 5'hE, 1'b0);
    cycle(1'b1, 5'hF, 1'b0); cycle(1'b1, K_ENTER, 1'b0); cycle(1'b1, K_ENTER, 1'b0);
    chk("t5_x_before", 32'(bus.x_out), 32'hBEEF);
    bus.key_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(bus.op_valid), 32'd0);
    chk("t5_x", 32'(bus.x_out), 32'h0);
    chk("t5_ready", 32'(bus.key_ready), 32'd1);
    model_clear();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Plan 6: reserved codes are swallowed.
    key(5'h12); key(5'h2); key(5'h1F); key(5'hA);
    chk("t6_x", 32'(bus.x_out), 32'h002A);
    chk("t6_cnt", 32'(bus.digit_cnt), 32'd2);
    chk("t6_ey", 32'(bus.entering_y), 32'd0);
    key(K_CLEAR);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [4:0] kc;
      r = int'($urandom_range(0, 99));
      if (r < 70)      kc = 5'($urandom_range(0, 15));
      else if (r < 88) kc = K_ENTER;
      else if (r < 93) kc = K_CLEAR;
      else             kc = 5'($urandom_range(18, 31));
      cycle(($urandom_range(0, 3) != 0), kc, ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Upstream operand-capture stage for the 16-bit calculator datapath.
- Assembles two WIDTH-bit operands (X, Y) from a stream of keypad hex-digit codes and presents them as a stable pair through a valid/ready handshake.
- Consumers are the bitwise and arithmetic units (AND, OR, ADD, …), which read x_out and y_out.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of 4.
- DIGITS, WIDTH/4: maximum number of hex digits per operand (derived, not overridden).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- key_valid, input, 1: key code present this cycle.
- key_code, input, 5: 0x00–0x0F hex digit; 0x10 ENTER; 0x11 CLEAR; 0x12–0x1F reserved.
- key_ready, output, 1: block can accept a key. A key is accepted when key_valid && key_ready.
- x_out, output, WIDTH: operand X.
- y_out, output, WIDTH: operand Y.
- op_valid, output, 1: x_out/y_out pair is complete and stable.
- op_ready, input, 1: consumer accepts the pair. Transfer occurs when op_valid && op_ready.
- disp_out, output, WIDTH: operand currently being edited (x_out in S_X, y_out in S_Y/S_ISSUE).
- entering_y, output, 1: high in S_Y.
- digit_cnt, output, 3: digits entered into the current operand, 0..DIGITS.
- ovf, output, 1: sticky flag, set when a digit arrives while digit_cnt==DIGITS.

Behaviour:
- Reset (async assert, sync-free):
  - State S_X.
  - x_out=0, y_out=0, op_valid=0, ovf=0, digit_cnt=0, entering_y=0, key_ready=1, disp_out=0.
- All state updates are registered on rising clk. Outputs are register outputs or decodes of state; there are no combinational paths from key_* to outputs.
- States: S_X (edit X), S_Y (edit Y), S_ISSUE (pair offered).
- key_ready = 1 in S_X/S_Y and 0 in S_ISSUE. Keys presented in S_ISSUE are not consumed; upstream holds them.
- Accepted digit d in S_X or S_Y:
  - If digit_cnt < DIGITS: operand <= {operand[WIDTH-5:0], d}; digit_cnt += 1.
  - If digit_cnt == DIGITS: operand and count are unchanged; ovf <= 1.
- Accepted ENTER:
  - S_X -> S_Y: digit_cnt <= 0; y_out keeps its cleared value of 0.
  - S_Y -> S_ISSUE: op_valid <= 1 on the next edge, i.e. one-cycle latency from ENTER acceptance to op_valid.
  - ENTER with zero digits is legal; the operand is 0.
- Accepted CLEAR (S_X or S_Y):
  - -> S_X; x_out=0, y_out=0, digit_cnt=0, ovf=0.
- Reserved codes 0x12–0x1F are accepted (consumed) with no effect.
- S_ISSUE:
  - x_out and y_out are held constant while op_valid=1.
  - op_valid must not drop before the transfer.
  - On the transfer edge: op_valid <= 0, state <= S_X, x_out=y_out=0, digit_cnt=0, ovf=0.
  - key_ready returns to 1 in the cycle after the transfer.
- op_ready is ignored outside S_ISSUE.
- Reset asserted mid-operation, including in S_ISSUE with op_valid=1, immediately forces the reset values. The pending pair is discarded.
- digit_cnt saturates at DIGITS and never wraps.

Test Plan:
1. Keys A,B,C,D,ENTER,0,F,0,F,ENTER with op_ready=1 -> op_valid high exactly 1 cycle after the second ENTER is accepted; x_out=0xABCD, y_out=0x0F0F; both cleared and state S_X on the following cycle.
2. Keys 1,2,3,4,5 -> x_out=0x1234, digit_cnt=4, ovf=1. Then ENTER,ENTER -> pair issued with y_out=0x0000 and ovf cleared after transfer.
3. Reach S_ISSUE with op_ready=0 for 5 cycles while key_valid=1 (digit 7) -> key_ready=0, op_valid=1, operands unchanged throughout. Raise op_ready -> transfer; digit 7 is then accepted into X (x_out=0x0007).
4. Keys 9,ENTER,5,CLEAR,3 -> state S_X, x_out=0x0003, y_out=0, entering_y=0.
5. rst_n low for 1 cycle while op_valid=1 (x=0xBEEF) -> op_valid=0, x_out=0, state S_X immediately, with no clock edge needed.
6. Key codes 0x12 and 0x1F interleaved with digits 2,A -> x_out=0x002A, digit_cnt=2, no state change from reserved codes.
